pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Parametrised successor of the two-phase pipeline controller for the Dec/Exe/WB microprocessor pipeline. It generates the pipeline write strobes, selects operand forwarding from N result sources, and raises stalls and flushes. Stalls cover not-yet-ready results and a busy multi-cycle multiplier; flushes cover taken branches. It sits between the decode stage, the Dec/Exe and Exe/WB buffers, the register bank and the operand muxes.

Parameters:
RADDR_W, 4, register address width
NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority
MUL_LAT, 3, multiplier busy cycles after a MUL commits (>=1)
SEL_W, $clog2(NUM_FWD+1), width of the forward select outputs (derived)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-low reset
RegOpA  in  RADDR_W  source A address of the instruction in decode
RegOpB  in  RADDR_W  source B address of the instruction in decode
UseA  in  1  instruction reads A
UseB  in  1  instruction reads B
IsMul  in  1  decoded instruction is MUL
IsHiLo  in  1  decoded instruction is GHI/GLO
FwdDest  in  NUM_FWD*RADDR_W  destination of each source, packed; source k is at [k*RADDR_W +: RADDR_W]
FwdValid  in  NUM_FWD  source k will write back
FwdReady  in  NUM_FWD  source k result is available this cycle
BranchTaken  in  1  taken branch resolved in Exe
DecExeBufferWr  out  1  load Dec/Exe buffer
PCRegWr  out  1  load PC
ExeWbBufferWr  out  1  load Exe/WB buffer
RegBankWr  out  1  register bank write enable
FwdSelA  out  SEL_W  0 = register bank; k+1 = source k
FwdSelB  out  SEL_W  same for operand B
Stall  out  1  decode held
Flush  out  1  Dec/Exe loads a bubble (NOP)
MulBusy  out  1  multiplier occupied

Behaviour:
- State: Phase (1 bit), MulCnt ($clog2(MUL_LAT+1) bits), FlushPend (1 bit).
- Reset: while RST=0 on a CLK edge, Phase=0, MulCnt=0, FlushPend=0. While RST=0, all outputs are forced to 0. Reset mid-operation abandons any pending flush or multiply.
- Phase toggles every cycle: 0->1->0. After reset release, the first Phase=1 (commit) cycle is the 2nd cycle.
- Phase 0 (fetch/operand read):
  - RegBankWr=1; DecExeBufferWr=PCRegWr=ExeWbBufferWr=0.
- Phase 1 (commit):
  - RegBankWr=0.
  - ExeWbBufferWr=1.
  - DecExeBufferWr=PCRegWr=~Stall.
- Match: source k matches A when UseA & FwdValid[k] & (FwdDest[k]==RegOpA). B is the same with UseB/RegOpB.
- FwdSelA = k+1 for the lowest matching k, else 0. FwdSelB is the same. Purely combinational, valid in both phases.
- Data stall: the lowest-index matching source for A or B has FwdReady=0. An older ready match does not hide a younger unready one.
- Mul stall: (IsMul | IsHiLo) & MulBusy.
- Stall = (data stall | mul stall) & ~Flush. Stall is combinational in both phases; the strobes only act in phase 1.
- MulBusy = (MulCnt!=0). MulCnt update:
  - Phase-1 cycle with IsMul & ~Stall & ~Flush: load MUL_LAT.
  - Otherwise, if nonzero, decrement by 1 each cycle.
  - Load has priority over decrement.
- Flush:
  - BranchTaken on a phase-1 cycle with FlushPend=0 sets FlushPend.
  - Flush = FlushPend.
  - FlushPend clears at the end of the next phase-1 cycle.
  - During that phase-1 cycle, DecExeBufferWr=PCRegWr=1 and the datapath writes a NOP.
  - BranchTaken while FlushPend=1 is ignored (the instruction in Exe is a bubble).
  - BranchTaken in phase 0 is ignored.
- Flush beats stall: a stalled wrong-path instruction is discarded, not held, and a flushed MUL does not load MulCnt.

Optional Feature:
Macro ZERO_REG_EN.
- Defined: address 0 is hard-zero. An operand address of 0 never matches any source, so FwdSel=0 and it causes no data stall. FwdValid with FwdDest=0 is treated as no writeback.
- Undefined: address 0 is an ordinary register and is forwarded and stalled like any other.

Test Plan:
1. Reset: hold RST=0 for 3 cycles, release -> all outputs 0 during reset; RegBankWr=1 in the 1st cycle after release; DecExeBufferWr=PCRegWr=ExeWbBufferWr=1 in the 2nd; alternation continues.
2. Forward priority (defaults): RegOpA=5, UseA=1, FwdDest={src1=5, src0=5}, FwdValid=2'b11, FwdReady=2'b11 -> FwdSelA=1. With FwdValid=2'b10 -> FwdSelA=2. With FwdValid=0 -> FwdSelA=0.
3. Data stall: RegOpB=3, UseB=1, src0 dest 3, FwdReady[0]=0 for one phase pair, then 1 -> Stall=1 and DecExeBufferWr=PCRegWr=0 on that commit; released on the next commit with FwdSelB=1.
4. Multiplier: MUL commits, then GHI decoded immediately (MUL_LAT=3) -> MulBusy high for 3 cycles; GHI stalls exactly one commit, then commits with MulBusy=0.
5. Branch flush while stalled: stall condition active and BranchTaken=1 on a commit -> the next commit has Flush=1, Stall=0, DecExeBufferWr=1; Flush=0 afterwards. A second BranchTaken during Flush is ignored.
6. ZERO_REG_EN defined: RegOpA=0, src0 dest 0, FwdValid[0]=1, FwdReady[0]=0 -> FwdSelA=0, Stall=0. Undefined -> FwdSelA=1, Stall=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : two-phase Dec/Exe/WB pipeline controller with forwarding select, stall and flush.
// Latency : strobes, forward selects and stall are combinational; flush appears one cycle after the branch commit.
// Backpressure: Stall holds decode and gates DecExeBufferWr/PCRegWr on the commit phase; Flush overrides Stall.
//
// Ports:
//   CLK, RST           clock, synchronous active-low reset (all outputs forced low while RST=0)
//   RegOpA/B, UseA/B   operand addresses and use flags of the instruction in decode
//   IsMul, IsHiLo      decoded MUL / GHI-GLO
//   FwdDest/Valid/Ready  per-source destination, writeback flag and result availability
//   BranchTaken        taken branch resolved in Exe
//   DecExeBufferWr, PCRegWr, ExeWbBufferWr, RegBankWr   pipeline write strobes
//   FwdSelA/B          0 = register bank, k+1 = forwarding source k
//   Stall, Flush, MulBusy
// Optional feature: define ZERO_REG_EN to make register 0 hard-zero (never forwarded, never stalls).

module pipe_hazard_ctrl #(
  parameter int RADDR_W = 4,
  parameter int NUM_FWD = 2,
  parameter int MUL_LAT = 3,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [RADDR_W-1:0]         RegOpA,
  input  logic [RADDR_W-1:0]         RegOpB,
  input  logic                       UseA,
  input  logic                       UseB,
  input  logic                       IsMul,
  input  logic                       IsHiLo,
  input  logic [NUM_FWD*RADDR_W-1:0] FwdDest,
  input  logic [NUM_FWD-1:0]         FwdValid,
  input  logic [NUM_FWD-1:0]         FwdReady,
  input  logic                       BranchTaken,
  output logic                       DecExeBufferWr,
  output logic                       PCRegWr,
  output logic                       ExeWbBufferWr,
  output logic                       RegBankWr,
  output logic [SEL_W-1:0]           FwdSelA,
  output logic [SEL_W-1:0]           FwdSelB,
  output logic                       Stall,
  output logic                       Flush,
  output logic                       MulBusy
);

  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  logic             phase_q, phase_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic [RADDR_W-1:0] fwd_dest [NUM_FWD];
  logic [NUM_FWD-1:0] match_a, match_b;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic               rdy_a, rdy_b;
  logic               data_stall, mul_stall, mul_busy, stall_int;

  // Source matching against both operands.
  always_comb begin
    for (int k = 0; k < NUM_FWD; k++) begin
      fwd_dest[k] = FwdDest[k*RADDR_W +: RADDR_W];
`ifdef ZERO_REG_EN
      // Register 0 is hard-zero: neither a zero operand nor a zero destination can match.
      match_a[k] = UseA & FwdValid[k] & (fwd_dest[k] == RegOpA)
                 & (RegOpA != '0) & (fwd_dest[k] != '0);
      match_b[k] = UseB & FwdValid[k] & (fwd_dest[k] == RegOpB)
                 & (RegOpB != '0) & (fwd_dest[k] != '0);
`else
      match_a[k] = UseA & FwdValid[k] & (fwd_dest[k] == RegOpA);
      match_b[k] = UseB & FwdValid[k] & (fwd_dest[k] == RegOpB);
`endif
    end
  end

  // Walk from oldest to youngest so the youngest (lowest index) match wins;
  // its readiness alone decides the data stall, an older ready copy is stale.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        sel_a = SEL_W'(k + 1);
        rdy_a = FwdReady[k];
      end
      if (match_b[k]) begin
        sel_b = SEL_W'(k + 1);
        rdy_b = FwdReady[k];
      end
    end
  end

  assign mul_busy   = (mul_cnt_q != '0);
  assign data_stall = ~rdy_a | ~rdy_b;
  assign mul_stall  = (IsMul | IsHiLo) & mul_busy;
  // A pending flush discards the decode instruction, so it must not be held.
  assign stall_int  = (data_stall | mul_stall) & ~flush_pend_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      phase_q      <= 1'b0;
      mul_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      mul_cnt_q    <= mul_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic.
  always_comb begin
    phase_d      = ~phase_q;
    mul_cnt_d    = mul_cnt_q;
    flush_pend_d = flush_pend_q;

    // A MUL only occupies the multiplier if it actually commits.
    if (phase_q & IsMul & ~stall_int & ~flush_pend_q) begin
      mul_cnt_d = CNT_W'(MUL_LAT);
    end else if (mul_busy) begin
      mul_cnt_d = mul_cnt_q - CNT_W'(1);
    end

    // The flush commit ends the pending flush; a branch seen on that commit
    // belongs to the bubble in Exe and is dropped.
    if (phase_q) begin
      if (flush_pend_q) begin
        flush_pend_d = 1'b0;
      end else if (BranchTaken) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // Output logic, all forced low during reset.
  always_comb begin
    DecExeBufferWr = 1'b0;
    PCRegWr        = 1'b0;
    ExeWbBufferWr  = 1'b0;
    RegBankWr      = 1'b0;
    FwdSelA        = '0;
    FwdSelB        = '0;
    Stall          = 1'b0;
    Flush          = 1'b0;
    MulBusy        = 1'b0;
    if (RST) begin
      RegBankWr      = ~phase_q;
      ExeWbBufferWr  = phase_q;
      DecExeBufferWr = phase_q & ~stall_int;
      PCRegWr        = phase_q & ~stall_int;
      FwdSelA        = sel_a;
      FwdSelB        = sel_b;
      Stall          = stall_int;
      Flush          = flush_pend_q;
      MulBusy        = mul_busy;
    end
  end

endmodule
